axis_cfg_sched: RTL and testbench



---
 rtl/axis_cfg_sched_if.sv | 27 ++
 rtl/axis_cfg_sched.sv | 156 +++++++++++++++
 tb/tb_axis_cfg_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_cfg_sched_if.sv
// Descriptor-request and config-bus signals shared by axis_cfg_sched and its environment.
// The slave modport is the scheduler's view; master is the requester/engine side.
interface axis_cfg_sched_if #(
  parameter int N_REQ      = 4,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*CFG_DWIDTH-1:0] req_addr;
  logic [N_REQ*CFG_DWIDTH-1:0] req_len;
  logic [N_REQ-1:0]            eng_rdy;
  logic [CFG_AWIDTH-1:0]       cfg_addr;
  logic [CFG_DWIDTH-1:0]       cfg_data;
  logic                        cfg_valid;
  logic                        busy;

  modport slave (
    input  req_valid, req_addr, req_len, eng_rdy,
    output req_ready, cfg_addr, cfg_data, cfg_valid, busy
  );

  modport master (
    output req_valid, req_addr, req_len, eng_rdy,
    input  req_ready, cfg_addr, cfg_data, cfg_valid, busy
  );
endinterface

// File: rtl/axis_cfg_sched.sv
// Round-robin scheduler serialising one winning descriptor at a time into the
// three-beat engine config sequence (ID, address, length) followed by a gap cycle.
module axis_cfg_sched #(
  parameter int N_REQ       = 4,
  parameter int ID_BASE     = 1,
  parameter int CFG_ADDR    = 23,
  parameter int CFG_DATA    = 24,
  parameter int CFG_AWIDTH  = 5,
  parameter int CFG_DWIDTH  = 32,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  axis_cfg_sched_if.slave    bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  // The grant cycle itself counts as the first holdoff cycle, so grant spacing equals HOLD_CYCLES.
  localparam logic [HW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ID   = 5'b00010,
    S_ADDR = 5'b00100,
    S_LEN  = 5'b01000,
    S_GAP  = 5'b10000
  } state_t;

  state_t                r_state, w_state_next;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         w_grant_idx;
  logic                  w_grant_any;
  logic                  w_take;
  logic [N_REQ-1:0]      w_elig;
  logic [CFG_DWIDTH-1:0] r_addr, r_len;
  logic [CFG_DWIDTH-1:0] w_sel_addr, w_sel_len;
  logic [CFG_AWIDTH-1:0] r_cfg_addr, w_cfg_addr_next;
  logic [CFG_DWIDTH-1:0] r_cfg_data, w_cfg_data_next;
  logic                  r_cfg_valid, w_cfg_valid_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_hold
      logic [HW-1:0] r_hold;

      always_ff @(posedge clk) begin
        if (rst)
          r_hold <= '0;
        else if (w_take && (w_grant_idx == IW'(gi)))
          r_hold <= HOLD_LOAD;
        else if (r_hold != '0)
          r_hold <= r_hold - 1'b1;
      end

      assign w_elig[gi] = bus.req_valid[gi] & bus.eng_rdy[gi] & (r_hold == '0);
    end
  endgenerate

  // Search upward from last_grant+1 so the most recently served requester goes last.
  always_comb begin
    int c;
    c           = 0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = int'(r_last_grant) + k;
      if (c >= N_REQ)
        c = c - N_REQ;
      if (!w_grant_any && w_elig[IW'(c)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = IW'(c);
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && w_grant_any && !rst;

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant_idx == IW'(k)) begin
        w_sel_addr = bus.req_addr[k*CFG_DWIDTH +: CFG_DWIDTH];
        w_sel_len  = bus.req_len[k*CFG_DWIDTH +: CFG_DWIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_take)
      bus.req_ready[w_grant_idx] = 1'b1;
  end

  // Config registers are loaded with the beat belonging to the state being entered.
  always_comb begin
    w_state_next     = r_state;
    w_cfg_valid_next = 1'b0;
    w_cfg_addr_next  = r_cfg_addr;
    w_cfg_data_next  = r_cfg_data;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_next     = S_ID;
          w_cfg_valid_next = 1'b1;
          w_cfg_addr_next  = CFG_AWIDTH'(CFG_ADDR);
          w_cfg_data_next  = CFG_DWIDTH'(ID_BASE) + CFG_DWIDTH'(w_grant_idx);
        end
      end
      S_ID: begin
        w_state_next     = S_ADDR;
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = CFG_AWIDTH'(CFG_DATA);
        w_cfg_data_next  = r_addr;
      end
      S_ADDR: begin
        w_state_next     = S_LEN;
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = CFG_AWIDTH'(CFG_DATA);
        w_cfg_data_next  = r_len;
      end
      S_LEN:   w_state_next = S_GAP;
      S_GAP:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cfg_valid  <= 1'b0;
      r_cfg_addr   <= '0;
      r_cfg_data   <= '0;
      r_last_grant <= IW'(N_REQ - 1);
    end else begin
      r_state     <= w_state_next;
      r_cfg_valid <= w_cfg_valid_next;
      r_cfg_addr  <= w_cfg_addr_next;
      r_cfg_data  <= w_cfg_data_next;
      if (w_take)
        r_last_grant <= w_grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_addr <= w_sel_addr;
      r_len  <= w_sel_len;
    end
  end

  assign bus.cfg_addr  = r_cfg_addr;
  assign bus.cfg_data  = r_cfg_data;
  assign bus.cfg_valid = r_cfg_valid;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_axis_cfg_sched.sv
// Scoreboard bench: two schedulers (holdoff 8 and holdoff 0) driven one at a time;
// stimulus queues expected grants/beats, a negedge monitor pops and compares.
module tb_axis_cfg_sched;
  logic clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_g [2];

  typedef struct {
    int          dut;
    bit          beat;
    int          idx;
    int          at;
    int          gap;
    int          off;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  axis_cfg_sched_if #(.N_REQ(4), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) bus_a ();
  axis_cfg_sched_if #(.N_REQ(4), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) bus_b ();

  axis_cfg_sched #(.HOLD_CYCLES(8)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  axis_cfg_sched #(.HOLD_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_grant(input int d, input int idx, input int at, input int gap);
    exp_t e;
    e.dut = d; e.beat = 1'b0; e.idx = idx; e.at = at; e.gap = gap;
    e.off = 0; e.a = '0; e.d = '0;
    q.push_back(e);
  endtask

  task automatic push_beat(input int d, input int off, input logic [4:0] a, input logic [31:0] dat);
    exp_t e;
    e.dut = d; e.beat = 1'b1; e.idx = 0; e.at = -1; e.gap = 0;
    e.off = off; e.a = a; e.d = dat;
    q.push_back(e);
  endtask

  task automatic push_seq(input int d, input int idx, input int at, input int gap,
                          input logic [31:0] addr, input logic [31:0] len);
    push_grant(d, idx, at, gap);
    push_beat(d, 1, 5'd23, 32'(1 + idx));
    push_beat(d, 2, 5'd24, addr);
    push_beat(d, 3, 5'd24, len);
  endtask

  task automatic mon(input int d, input logic [3:0] rdy, input logic v,
                     input logic [4:0] a, input logic [31:0] dat);
    exp_t e;
    logic [3:0] oh;
    bit ok;
    if (rdy != 4'b0000) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL grant_unexpected dut%0d cyc %0d: got req_ready=%b, required no grant", d, cyc, rdy);
      end else begin
        e  = q.pop_front();
        oh = 4'b0001 << e.idx;
        ok = (e.dut == d) && !e.beat && (rdy == oh) && (e.at < 0 || e.at == cyc) &&
             (e.gap == 0 || (cyc - last_g[d]) == e.gap);
        if (!ok) begin
          n_bad++;
          $display("FAIL grant dut%0d cyc %0d: got req_ready=%b gap=%0d, required dut%0d beat=%0d ready=%b at=%0d gap=%0d",
                   d, cyc, rdy, cyc - last_g[d], e.dut, e.beat, oh, e.at, e.gap);
        end else
          $display("grant dut%0d cyc %0d req_ready=%b ok", d, cyc, rdy);
      end
      last_g[d] = cyc;
    end
    if (v) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected dut%0d cyc %0d: got (%0d,%h), required no beat", d, cyc, a, dat);
      end else begin
        e  = q.pop_front();
        ok = (e.dut == d) && e.beat && (a == e.a) && (dat == e.d) && ((cyc - last_g[d]) == e.off);
        if (!ok) begin
          n_bad++;
          $display("FAIL beat dut%0d cyc %0d: got (%0d,%h) off=%0d, required dut%0d beat=%0d (%0d,%h) off=%0d",
                   d, cyc, a, dat, cyc - last_g[d], e.dut, e.beat, e.a, e.d, e.off);
        end else
          $display("beat dut%0d cyc %0d (%0d,%h) ok", d, cyc, a, dat);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.req_ready, bus_a.cfg_valid, bus_a.cfg_addr, bus_a.cfg_data);
    mon(1, bus_b.req_ready, bus_b.cfg_valid, bus_b.cfg_addr, bus_b.cfg_data);
  end

  initial begin
    int c;
    last_g[0] = 0;
    last_g[1] = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req_valid = '0; bus_a.eng_rdy = 4'b1111; bus_a.req_addr = '0; bus_a.req_len = '0;
    bus_b.req_valid = '0; bus_b.eng_rdy = 4'b1111; bus_b.req_addr = '0; bus_b.req_len = '0;
    tick(3);

    chk("rst_ready_a", 32'(bus_a.req_ready), 32'd0);
    chk("rst_valid_a", 32'(bus_a.cfg_valid), 32'd0);
    chk("rst_addr_a",  32'(bus_a.cfg_addr),  32'd0);
    chk("rst_data_a",  bus_a.cfg_data,       32'd0);
    chk("rst_busy_a",  32'(bus_a.busy),      32'd0);
    chk("rst_valid_b", 32'(bus_b.cfg_valid), 32'd0);
    chk("rst_busy_b",  32'(bus_b.busy),      32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick(1);

    // Holdoff 0: all four valid, rotation 0,1,2,3,0 five cycles apart
    for (int i = 0; i < 4; i++) begin
      bus_b.req_addr[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      bus_b.req_len[i*32 +: 32]  = 32'h0000_0100 + 32'(i);
    end
    c = cyc;
    push_seq(1, 0, c, 0, 32'hA000_0000, 32'h100);
    push_seq(1, 1, -1, 5, 32'hA000_0001, 32'h101);
    push_seq(1, 2, -1, 5, 32'hA000_0002, 32'h102);
    push_seq(1, 3, -1, 5, 32'hA000_0003, 32'h103);
    push_seq(1, 0, -1, 5, 32'hA000_0000, 32'h100);
    bus_b.req_valid = 4'b1111;
    tick(21);
    bus_b.req_valid = 4'b0000;
    tick(10);

    // Set last_grant=1, then requesters 1 and 3: 3 first, then 1
    push_seq(1, 1, cyc, 0, 32'hA000_0001, 32'h101);
    bus_b.req_valid = 4'b0010;
    tick(1);
    bus_b.req_valid = 4'b0000;
    tick(6);
    c = cyc;
    push_seq(1, 3, c, 0, 32'hA000_0003, 32'h103);
    push_seq(1, 1, -1, 5, 32'hA000_0001, 32'h101);
    bus_b.req_valid = 4'b1010;
    tick(6);
    bus_b.req_valid = 4'b0000;
    tick(8);

    // Single request on requester 2
    bus_a.req_addr[2*32 +: 32] = 32'h1000_0000;
    bus_a.req_len[2*32 +: 32]  = 32'h0000_0040;
    push_seq(0, 2, cyc, 0, 32'h1000_0000, 32'h40);
    bus_a.req_valid = 4'b0100;
    tick(1);
    bus_a.req_valid = 4'b0000;
    tick(8);

    // Engine not ready for 10 cycles, grant on the first ready cycle
    bus_a.req_addr[0*32 +: 32] = 32'h0000_0AB0;
    bus_a.req_len[0*32 +: 32]  = 32'h0000_0010;
    bus_a.eng_rdy   = 4'b0000;
    bus_a.req_valid = 4'b0001;
    tick(10);
    push_seq(0, 0, cyc, 0, 32'h0000_0AB0, 32'h10);
    bus_a.eng_rdy = 4'b0001;
    tick(1);
    bus_a.req_valid = 4'b0000;
    bus_a.eng_rdy   = 4'b1111;
    tick(8);

    // Holdoff 8: requester 1 alone, grants 8 cycles apart
    bus_a.req_addr[1*32 +: 32] = 32'h5555_0000;
    bus_a.req_len[1*32 +: 32]  = 32'h0000_0200;
    c = cyc;
    push_seq(0, 1, c, 0, 32'h5555_0000, 32'h200);
    push_seq(0, 1, -1, 8, 32'h5555_0000, 32'h200);
    push_seq(0, 1, -1, 8, 32'h5555_0000, 32'h200);
    bus_a.req_valid = 4'b0010;
    tick(17);
    bus_a.req_valid = 4'b0000;
    tick(10);

    // Reset while the address beat is on the bus
    bus_a.req_addr[2*32 +: 32] = 32'h2222_0000;
    bus_a.req_len[2*32 +: 32]  = 32'h0000_0022;
    c = cyc;
    push_grant(0, 2, c, 0);
    push_beat(0, 1, 5'd23, 32'd3);
    push_beat(0, 2, 5'd24, 32'h2222_0000);
    bus_a.req_valid = 4'b0101;
    tick(2);
    rst_a = 1'b1;
    tick(1);
    chk("mid_rst_valid", 32'(bus_a.cfg_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus_a.busy),      32'd0);
    rst_a = 1'b0;
    push_seq(0, 0, cyc, 0, 32'h0000_0AB0, 32'h10);
    tick(1);
    bus_a.req_valid = 4'b0000;
    tick(10);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
